// File: rtl/layer_pkg.sv
// Types and widths shared by the layer sequencer and the layer-count stage it drives.
package layer_pkg;

  localparam int CH    = 8;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  typedef struct packed {
    logic [CH-1:0]    cfg;
    logic [CNT_W-1:0] cnt;
    logic             base;
  } layer_entry_t;

endpackage

// File: rtl/layer_sequencer_if.sv
// Sequencer <-> layer-count stage link: entry outputs forward, end pulse back.
interface layer_sequencer_if;
  import layer_pkg::*;

  logic [CH-1:0]    layerCfg;
  logic [CNT_W-1:0] layerCnt;
  logic             BaseLayer;
  logic             layerEnd;

  modport master (output layerCfg, layerCnt, BaseLayer, input layerEnd);
  modport slave  (input layerCfg, layerCnt, BaseLayer, output layerEnd);

endinterface

// File: rtl/layer_table.sv
// Layer entry register array: one write port, registered read of the addressed entry.
module layer_table
  import layer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         we_i,
  input  logic [AW-1:0] waddr_i,
  input  layer_entry_t wdata_i,
  input  logic [AW-1:0] raddr_i,
  output layer_entry_t rdata_o
);

  layer_entry_t mem_q [DEPTH];
  layer_entry_t rdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/layer_sequencer.sv
// Steps through the layer table, one LOAD gap per entry change, looping the
// sequence seqRepeat times (0 = forever) and pulsing done on completion.
module layer_sequencer
  import layer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             io_clk,
  input  logic             io_rst,
  input  logic             io_start,
  input  logic             io_abort,
  input  logic [AW:0]      io_seqLen,
  input  logic [CNT_W-1:0] io_seqRepeat,
  input  logic             io_wrEn,
  input  logic [AW-1:0]    io_wrAddr,
  input  logic [CH-1:0]    io_wrCfg,
  input  logic [CNT_W-1:0] io_wrCnt,
  input  logic             io_wrBase,
  layer_sequencer_if.master io_layer,
  output logic [AW-1:0]    io_layerIdx,
  output logic [CNT_W-1:0] io_passCnt,
  output logic             io_busy,
  output logic             io_done,
  output logic             io_cfgErr
);

  localparam logic [AW:0]      LEN_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0]    IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] PASS_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [AW:0]      LEN_MAX  = (AW+1)'(DEPTH);

  state_e           state_q;
  logic [AW:0]      len_q;
  logic [CNT_W-1:0] rep_q, pass_q;
  logic [AW-1:0]    idx_q, idx_d;
  logic             busy_q, done_q, err_q;
  layer_entry_t     out_q, rd_entry, wr_entry;
  logic             last_entry, len_ok, more_passes, advance;

  assign last_entry  = ({1'b0, idx_q} == (len_q - LEN_ONE));
  assign len_ok      = (io_seqLen != '0) && (io_seqLen <= LEN_MAX);
  assign more_passes = (rep_q == '0) || (pass_q < (rep_q - PASS_ONE));
  assign advance     = (state_q == RUN) && io_layer.layerEnd && !io_abort;

  // The table read is registered, so it is addressed with the next index to
  // have the entry ready by the end of the LOAD cycle.
  assign idx_d = advance ? (last_entry ? '0 : idx_q + IDX_ONE) : idx_q;

  assign wr_entry.cfg  = io_wrCfg;
  assign wr_entry.cnt  = io_wrCnt;
  assign wr_entry.base = io_wrBase;

  layer_table #(.DEPTH(DEPTH), .AW(AW)) u_table (
    .clk_i   (io_clk),
    .rst_i   (io_rst),
    .we_i    (io_wrEn && (state_q == IDLE)),
    .waddr_i (io_wrAddr),
    .wdata_i (wr_entry),
    .raddr_i (idx_d),
    .rdata_o (rd_entry)
  );

  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      rep_q   <= '0;
      pass_q  <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= (state_q != IDLE) && (io_wrEn || (io_start && !io_abort));
      if (io_abort && (state_q != IDLE)) begin
        state_q <= IDLE;
        out_q   <= '0;
        idx_q   <= '0;
        pass_q  <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (io_start && !io_abort) begin
              if (len_ok) begin
                state_q <= LOAD;
                len_q   <= io_seqLen;
                rep_q   <= io_seqRepeat;
                idx_q   <= '0;
                pass_q  <= '0;
                busy_q  <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          LOAD: begin
            state_q <= RUN;
            out_q   <= rd_entry;
          end
          RUN: begin
            if (io_layer.layerEnd) begin
              out_q.cfg <= '0;
              if (!last_entry) begin
                idx_q   <= idx_d;
                state_q <= LOAD;
              end else if (more_passes) begin
                idx_q   <= '0;
                pass_q  <= (pass_q != '1) ? pass_q + PASS_ONE : pass_q;
                state_q <= LOAD;
              end else begin
                pass_q  <= pass_q + PASS_ONE;
                idx_q   <= '0;
                out_q   <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= DONE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign io_layer.layerCfg  = out_q.cfg;
  assign io_layer.layerCnt  = out_q.cnt;
  assign io_layer.BaseLayer = out_q.base;
  assign io_layerIdx = idx_q;
  assign io_passCnt  = pass_q;
  assign io_busy     = busy_q;
  assign io_done     = done_q;
  assign io_cfgErr   = err_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: entry-level reference model checked every cycle,
// plus hand-computed literal checks on each scenario.
module tb_layer_sequencer;
  import layer_pkg::*;

  logic             io_clk, io_rst, io_start, io_abort;
  logic [4:0]       io_seqLen;
  logic [15:0]      io_seqRepeat;
  logic             io_wrEn;
  logic [3:0]       io_wrAddr;
  logic [7:0]       io_wrCfg;
  logic [15:0]      io_wrCnt;
  logic             io_wrBase;
  logic [3:0]       io_layerIdx;
  logic [15:0]      io_passCnt;
  logic             io_busy, io_done, io_cfgErr;

  layer_sequencer_if lif();

  layer_sequencer dut (
    .io_clk(io_clk), .io_rst(io_rst), .io_start(io_start), .io_abort(io_abort),
    .io_seqLen(io_seqLen), .io_seqRepeat(io_seqRepeat), .io_wrEn(io_wrEn),
    .io_wrAddr(io_wrAddr), .io_wrCfg(io_wrCfg), .io_wrCnt(io_wrCnt),
    .io_wrBase(io_wrBase), .io_layer(lif), .io_layerIdx(io_layerIdx),
    .io_passCnt(io_passCnt), .io_busy(io_busy), .io_done(io_done), .io_cfgErr(io_cfgErr)
  );

  initial io_clk = 1'b0;
  always #5 io_clk = ~io_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: tracks which entry of which pass is live and whether the
  // outputs are in the one-cycle gap after an entry change.
  int  tbl_cfg [16];
  int  tbl_cnt [16];
  int  tbl_base[16];
  bit  m_active, m_gap, m_done, m_err;
  int  m_idx, m_pass, m_len, m_rep;

  task automatic model_step();
    bit was_done;
    was_done = m_done;
    m_done = 0;
    m_err  = 0;
    if (io_rst) begin
      for (int i = 0; i < 16; i++) begin tbl_cfg[i] = 0; tbl_cnt[i] = 0; tbl_base[i] = 0; end
      m_active = 0; m_gap = 0; m_idx = 0; m_pass = 0; m_len = 0; m_rep = 0;
    end else if (!m_active) begin
      if (io_wrEn) begin
        if (was_done) m_err = 1;
        else begin
          tbl_cfg[io_wrAddr] = io_wrCfg; tbl_cnt[io_wrAddr] = io_wrCnt; tbl_base[io_wrAddr] = io_wrBase;
        end
      end
      if (io_abort) begin
        if (was_done) m_pass = 0;
      end else if (io_start) begin
        if (was_done || io_seqLen == 0 || io_seqLen > 16) m_err = 1;
        else begin
          m_active = 1; m_gap = 1; m_idx = 0; m_pass = 0;
          m_len = int'(io_seqLen); m_rep = int'(io_seqRepeat);
        end
      end
    end else begin
      if (io_wrEn) m_err = 1;
      if (io_abort) begin
        m_active = 0; m_gap = 0; m_idx = 0; m_pass = 0;
      end else begin
        if (io_start) m_err = 1;
        if (m_gap) m_gap = 0;
        else if (lif.layerEnd) begin
          if (m_idx + 1 < m_len) begin
            m_idx++; m_gap = 1;
          end else if (m_rep == 0 || m_pass + 1 < m_rep) begin
            m_idx = 0; m_gap = 1;
            if (m_pass != 65535) m_pass++;
          end else begin
            m_pass++; m_active = 0; m_idx = 0; m_done = 1;
          end
        end
      end
    end
  endtask

  always @(posedge io_clk) begin
    bit live;
    model_step();
    #1;
    live = m_active && !m_gap;
    if (io_done) n_done++;
    check("cyc_busy", io_busy, m_active);
    check("cyc_idx", io_layerIdx, m_idx);
    check("cyc_pass", io_passCnt, m_pass);
    check("cyc_done", io_done, m_done);
    check("cyc_err", io_cfgErr, m_err);
    check("cyc_cfg", lif.layerCfg, live ? tbl_cfg[m_idx] : 0);
    if (!(m_active && m_gap)) begin
      check("cyc_cnt", lif.layerCnt, live ? tbl_cnt[m_idx] : 0);
      check("cyc_base", lif.BaseLayer, live ? tbl_base[m_idx] : 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge io_clk);
  endtask

  task automatic wr(input int a, input int c, input int n, input int b);
    io_wrEn = 1; io_wrAddr = 4'(a); io_wrCfg = 8'(c); io_wrCnt = 16'(n); io_wrBase = 1'(b);
    cyc(1);
    io_wrEn = 0;
  endtask

  task automatic start(input int len, input int rep);
    io_seqLen = 5'(len); io_seqRepeat = 16'(rep); io_start = 1;
    cyc(1);
    io_start = 0;
  endtask

  task automatic lend();
    lif.layerEnd = 1;
    cyc(1);
    lif.layerEnd = 0;
  endtask

  task automatic abort_pulse();
    io_abort = 1;
    cyc(1);
    io_abort = 0;
  endtask

  initial begin
    int seen[6];
    int exp_seq[6];
    int d0;
    exp_seq = '{0, 1, 0, 1, 0, 1};
    io_rst = 1; io_start = 0; io_abort = 0; io_seqLen = 0; io_seqRepeat = 0;
    io_wrEn = 0; io_wrAddr = 0; io_wrCfg = 0; io_wrCnt = 0; io_wrBase = 0;
    lif.layerEnd = 0;
    cyc(2);
    io_rst = 0;
    cyc(1);
    check("rst_busy", io_busy, 0);
    check("rst_cfg", lif.layerCfg, 0);
    check("rst_pass", io_passCnt, 0);

    // Three entries, single pass
    wr(0, 8'h01, 2, 0); wr(1, 8'h06, 1, 0); wr(2, 8'h80, 3, 1);
    d0 = n_done;
    start(3, 1);
    check("t1_load_busy", io_busy, 1);
    check("t1_load_cfg", lif.layerCfg, 0);
    cyc(1);
    check("t1_e0_cfg", lif.layerCfg, 8'h01);
    check("t1_e0_cnt", lif.layerCnt, 2);
    cyc(2);
    lend();
    check("t1_gap_cfg", lif.layerCfg, 0);
    check("t1_gap_idx", io_layerIdx, 1);
    cyc(1);
    check("t1_e1_cfg", lif.layerCfg, 8'h06);
    cyc(1);
    lend(); cyc(1);
    check("t1_e2_cfg", lif.layerCfg, 8'h80);
    check("t1_e2_cnt", lif.layerCnt, 3);
    check("t1_e2_base", lif.BaseLayer, 1);
    lend();
    check("t1_done", io_done, 1);
    check("t1_done_busy", io_busy, 0);
    cyc(1);
    check("t1_pass", io_passCnt, 1);
    check("t1_ndone", n_done - d0, 1);

    // Two entries, three passes
    d0 = n_done;
    start(2, 3); cyc(1);
    for (int k = 0; k < 6; k++) begin
      seen[k] = int'(io_layerIdx);
      lend();
      if (k < 5) cyc(1);
    end
    check("t2_done", io_done, 1);
    for (int k = 0; k < 6; k++) check("t2_idx_seq", seen[k], exp_seq[k]);
    cyc(1);
    check("t2_pass", io_passCnt, 3);
    check("t2_ndone", n_done - d0, 1);

    // Endless single-entry loop, then abort
    d0 = n_done;
    start(1, 0); cyc(1);
    for (int k = 0; k < 10; k++) begin lend(); cyc(1); end
    check("t3_busy", io_busy, 1);
    check("t3_pass", io_passCnt, 10);
    abort_pulse();
    check("t3_ab_busy", io_busy, 0);
    check("t3_ab_cfg", lif.layerCfg, 0);
    check("t3_ab_idx", io_layerIdx, 0);
    check("t3_ndone", n_done - d0, 0);

    // Illegal lengths and a write while running
    start(0, 1);
    check("t4_len0_err", io_cfgErr, 1);
    start(17, 1);
    check("t4_len17_err", io_cfgErr, 1);
    check("t4_len17_busy", io_busy, 0);
    start(1, 1); cyc(1);
    wr(0, 8'hFF, 99, 1);
    check("t4_wr_err", io_cfgErr, 1);
    lend(); cyc(1);
    start(1, 1); cyc(1);
    check("t4_rb_cfg", lif.layerCfg, 8'h01);
    check("t4_rb_cnt", lif.layerCnt, 2);
    abort_pulse();

    // layerEnd during LOAD is ignored; abort beats layerEnd
    d0 = n_done;
    start(3, 1); cyc(1);
    lend();
    lend();
    check("t5_load_end_idx", io_layerIdx, 1);
    check("t5_load_end_cfg", lif.layerCfg, 8'h06);
    lif.layerEnd = 1; io_abort = 1;
    cyc(1);
    lif.layerEnd = 0; io_abort = 0;
    check("t5_ab_busy", io_busy, 0);
    check("t5_ab_idx", io_layerIdx, 0);
    check("t5_ndone", n_done - d0, 0);

    // Asynchronous reset in the middle of a run
    start(3, 1); cyc(1);
    lend(); cyc(1);
    lend(); cyc(1);
    check("t6_pre_idx", io_layerIdx, 2);
    #2 io_rst = 1;
    #1;
    check("t6_rst_busy", io_busy, 0);
    check("t6_rst_cfg", lif.layerCfg, 0);
    check("t6_rst_cnt", lif.layerCnt, 0);
    check("t6_rst_idx", io_layerIdx, 0);
    @(negedge io_clk);
    io_rst = 0;
    cyc(1);
    start(1, 1); cyc(1);
    check("t6_tbl_cfg", lif.layerCfg, 0);
    check("t6_tbl_cnt", lif.layerCnt, 0);
    abort_pulse();
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, %0d checks made", n_tests);
    $fatal(1, "timeout");
  end

endmodule
